// File: rtl/parity_word_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module  : parity_word_checker_pkg
// Brief   : Shared buffer-state encodings and parity selector constants.
// Revision: 1.0
// ============================================================================
package parity_word_checker_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    // Padded to 32 bits so a plain "EVEN"/"ODD" override compares cleanly.
    localparam logic [31:0] PARITY_EVEN = "EVEN";
    localparam logic [31:0] PARITY_ODD  = {8'h00, "ODD"};

endpackage
`default_nettype wire

// File: rtl/parity_word_checker_skid.sv
`default_nettype none
// ============================================================================
// Module  : parity_word_checker_skid
// Brief   : Two-entry ready/valid skid buffer; full throughput, in_ready is a
//           decode of registered state only.
// Revision: 1.0
// ============================================================================
module parity_word_checker_skid
    import parity_word_checker_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    buf_state_t       r_state;
    buf_state_t       w_state_next;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_head_next;
    logic [WIDTH-1:0] w_skid_next;
    logic             w_in_xfer;
    logic             w_out_xfer;

    assign in_ready   = (r_state != TWO);
    assign out_valid  = (r_state != EMPTY);
    assign out_data   = r_head;
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_next;
            r_head  <= w_head_next;
            r_skid  <= w_skid_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_head_next  = r_head;
        w_skid_next  = r_skid;
        case (r_state)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_state_next = ONE;
                    w_head_next  = in_data;
                end
            end
            ONE: begin
                case ({w_in_xfer, w_out_xfer})
                    2'b10: begin
                        w_state_next = TWO;
                        w_skid_next  = in_data;
                    end
                    2'b11:   w_head_next  = in_data;
                    2'b01:   w_state_next = EMPTY;
                    default: w_state_next = ONE;
                endcase
            end
            TWO: begin
                // Input is blocked here, so only the drain edge matters.
                if (w_out_xfer) begin
                    w_state_next = ONE;
                    w_head_next  = r_skid;
                end
            end
            default: w_state_next = EMPTY;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/parity_word_checker.sv
`default_nettype none
// ============================================================================
// Module  : parity_word_checker
// Brief   : Recomputes parity on {parity, data} words, flags mismatches, keeps
//           a sticky error flag. Define PARITY_WORD_CHECKER_ERROR_COUNT_EN to
//           add the saturating error_count output.
// Revision: 1.0
// ============================================================================
module parity_word_checker
    import parity_word_checker_pkg::*;
#(
    parameter int          WORD_WIDTH        = 8,
    parameter logic [31:0] PARITY            = PARITY_EVEN,
    parameter int          ERROR_COUNT_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH:0]   in_word,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_parity_error,
    output logic                  error_sticky,
    input  logic                  error_clear
`ifdef PARITY_WORD_CHECKER_ERROR_COUNT_EN
    ,
    output logic [ERROR_COUNT_WIDTH-1:0] error_count
`endif
);

    localparam logic c_odd_select = (PARITY == PARITY_ODD);

    logic w_mismatch;
    logic w_bad_accept;
    logic r_error_sticky;

    assign w_mismatch   = (^in_word) != c_odd_select;
    assign w_bad_accept = in_valid & in_ready & w_mismatch;
    assign error_sticky = r_error_sticky;

    parity_word_checker_skid #(
        .WIDTH (WORD_WIDTH + 1)
    ) u_skid (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({w_mismatch, in_word[WORD_WIDTH-1:0]}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  ({out_parity_error, out_data})
    );

    // A bad accept wins over a simultaneous clear so no event is lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_error_sticky <= 1'b0;
        end else if (w_bad_accept) begin
            r_error_sticky <= 1'b1;
        end else if (error_clear) begin
            r_error_sticky <= 1'b0;
        end
    end

    if (ERROR_COUNT_WIDTH >= 1) begin : g_error_count
`ifdef PARITY_WORD_CHECKER_ERROR_COUNT_EN
        logic [ERROR_COUNT_WIDTH-1:0] r_error_count;

        assign error_count = r_error_count;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_error_count <= '0;
            end else if (w_bad_accept) begin
                if (error_clear) begin
                    r_error_count <= ERROR_COUNT_WIDTH'(1);
                end else if (r_error_count != '1) begin
                    r_error_count <= r_error_count + ERROR_COUNT_WIDTH'(1);
                end
            end else if (error_clear) begin
                r_error_count <= '0;
            end
        end
`endif
    end

endmodule
`default_nettype wire
